// File: rtl/cla_seq_pkg.sv
// Shared definitions for the chunked CLA add sequencer: FSM encoding and
// chunk-count / index-width helpers.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WIDTH_DEF  = 64;
  localparam int CHUNK_DEF  = 8;
  localparam int NUM_CHUNKS = WIDTH_DEF / CHUNK_DEF;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  function automatic int cla_num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a 1-bit index register.
  function automatic int cla_idx_w(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

endpackage

// File: rtl/cla_chunk_adder.sv
// Combinational W-bit carry-lookahead adder: {cout,sum} = a + b + cin.
module cla_chunk_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W-1:0] g, p;
  logic [W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is expanded as a sum of generate terms gated by the
  // propagates above them, so no carry depends on a lower computed carry.
  always_comb begin
    logic cc;
    logic term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      cc = cin;
      for (int j = 0; j <= i; j++) cc = cc & p[j];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        cc = cc | term;
      end
      c[i+1] = cc;
    end
  end

  assign sum  = p ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/cla_add_sequencer.sv
// Wide adder that time-multiplexes one CHUNK-bit CLA slice, low chunk first.
// Optional subtract mode is enabled with the CLA_SEQ_SUB_EN macro.
module cla_add_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy
);

  localparam int NC = cla_num_chunks(WIDTH, CHUNK);
  localparam int IW = cla_idx_w(NC);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [31:0]      base;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             ch_c;

  assign base = 32'(idx_q) * 32'(CHUNK);
  assign ch_a = a_q[base +: CHUNK];
  assign ch_b = b_q[base +: CHUNK];

  cla_chunk_adder #(.W(CHUNK)) u_add (
    .a    (ch_a),
    .b    (ch_b),
    .cin  (carry_q),
    .sum  (ch_s),
    .cout (ch_c)
  );

`ifndef CLA_SEQ_SUB_EN
  logic unused_sub;
  assign unused_sub = in_sub;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d   = in_a;
        idx_d = '0;
`ifdef CLA_SEQ_SUB_EN
        // Two's-complement subtract: a + ~b + 1; carry-out 1 means no borrow.
        b_d     = in_sub ? ~in_b : in_b;
        carry_d = in_sub;
`else
        b_d     = in_b;
        carry_d = 1'b0;
`endif
        state_d = RUN;
      end
      RUN: begin
        sum_d[base +: CHUNK] = ch_s;
        carry_d = ch_c;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NC - 1)) begin
          sum_d[WIDTH] = ch_c;
          idx_d        = '0;
          state_d      = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = rst_n && (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;

endmodule
